// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: hex font, segment bit
// positions and the inactive levels of the digit/segment lines.
package seg7_pkg;

  localparam int unsigned SEG_A  = 0;
  localparam int unsigned SEG_B  = 1;
  localparam int unsigned SEG_C  = 2;
  localparam int unsigned SEG_D  = 3;
  localparam int unsigned SEG_E  = 4;
  localparam int unsigned SEG_F  = 5;
  localparam int unsigned SEG_G  = 6;
  localparam int unsigned SEG_DP = 7;

  // Active-high glyphs, bit order g..a.
  localparam logic [6:0] FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [3:0] dig_off(input bit act_low);
    return act_low ? 4'hF : 4'h0;
  endfunction

  function automatic logic [7:0] seg_off(input bit act_low);
    return act_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display bus: word/controls into the scan driver, multiplexed lines out.
interface seg7_scan_driver_if;
  logic [15:0] dsp;
  logic        en;
  logic [3:0]  dp_mask;
  logic [7:0]  seg;
  logic [3:0]  dig;
  logic        frame_done;

  modport master (output dsp, en, dp_mask, input seg, dig, frame_done);
  modport slave  (input dsp, en, dp_mask, output seg, dig, frame_done);
endinterface

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// Combinational nibble-to-glyph decoder, active-high segments a..g.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = FONT[hex_i];
endmodule

// File: rtl/seg7_scan_driver.sv
// 4-digit multiplexed 7-segment driver: per-slot prescaler, digit index,
// frame-boundary shadow of the display word and registered line outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned BLANK_CYC   = 500,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned DIV = CLK_FREQ_HZ / SCAN_HZ;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX   = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    dig_q, dig_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_done_q, frame_done_d;

  logic          slot_end;
  logic          frame_end;
  logic          blank;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic [3:0]    dig_log;
  logic [7:0]    seg_log;

  hex_to_seg7 u_font (
    .hex_i (nibble),
    .seg_o (glyph)
  );

  always_comb begin
    slot_end     = (cnt_q == CNT_MAX);
    frame_end    = slot_end && (idx_q == 2'd3);
    cnt_d        = slot_end ? '0 : cnt_q + CW'(1);
    idx_d        = slot_end ? idx_q + 2'd1 : idx_q;
    // Shadow only moves at the frame boundary so a frame never mixes two words.
    shadow_d     = frame_end ? bus.dsp : shadow_q;
    frame_done_d = frame_end;

    nibble  = shadow_q[{idx_q, 2'b00} +: 4];
    blank   = !bus.en || (cnt_q < BLANK_CNT);
    dig_log = 4'h0;
    seg_log = 8'h00;
    if (!blank) begin
      dig_log         = 4'b0001 << idx_q;
      seg_log[6:0]    = glyph;
      seg_log[SEG_DP] = bus.dp_mask[idx_q];
    end
    dig_d = DIG_ACT_LOW ? ~dig_log : dig_log;
    seg_d = SEG_ACT_LOW ? ~seg_log : seg_log;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      shadow_q     <= 16'h0000;
      dig_q        <= dig_off(DIG_ACT_LOW);
      seg_q        <= seg_off(SEG_ACT_LOW);
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shadow_q     <= shadow_d;
      dig_q        <= dig_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dig        = dig_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=10, BLANK_CYC=2, active-low lines.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   fr       = 0;

  logic [3:0] dig_on [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .CLK_FREQ_HZ (1000),
    .SCAN_HZ     (100),
    .BLANK_CYC   (2),
    .SEG_ACT_LOW (1'b1),
    .DIG_ACT_LOW (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs n clock steps of a frame starting at a frame boundary. Step j's output
  // reflects scan state cnt=j%10, idx=j/10. Optional dsp change after step
  // chg_j; en dropped after step off_a and restored after step off_a+off_n.
  task automatic run_frame(input logic [7:0] s0, input logic [7:0] s1,
                           input logic [7:0] s2, input logic [7:0] s3,
                           input int n, input int chg_j, input logic [15:0] chg_dsp,
                           input int off_a, input int off_n);
    logic [7:0] s [4];
    logic       off;
    int         c, d;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    fr++;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      c   = j % 10;
      d   = j / 10;
      off = (c < 2) || (j > off_a && j <= off_a + off_n);
      chk($sformatf("dig f%0d j%0d", fr, j), {12'h0, bus.dig}, {12'h0, off ? 4'hF : dig_on[d]});
      chk($sformatf("seg f%0d j%0d", fr, j), {8'h0, bus.seg}, {8'h0, off ? 8'hFF : s[d]});
      chk($sformatf("frame_done f%0d j%0d", fr, j), {15'h0, bus.frame_done}, {15'h0, j == 39});
      if (j == chg_j) bus.dsp = chg_dsp;
      if (j == off_a) bus.en = 1'b0;
      if (j == off_a + off_n) bus.en = 1'b1;
    end
  endtask

  initial begin
    bus.dsp     = 16'h1234;
    bus.en      = 1'b1;
    bus.dp_mask = 4'b0000;
    repeat (3) @(posedge clk);
    #3;
    chk("reset dig", {12'h0, bus.dig}, 16'h000F);
    chk("reset seg", {8'h0, bus.seg}, 16'h00FF);
    chk("reset frame_done", {15'h0, bus.frame_done}, 16'h0000);
    rst = 1'b0;

    // Frame 1 shows the reset shadow (0000); dsp=1234 sampled at its end.
    run_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 40, -1, 16'h0, -100, 0);
    // Frame 2 shows 1234; switch to ABCD mid-frame for the next one.
    run_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 40, 20, 16'hABCD, -100, 0);
    // Frame 3 shows ABCD despite dsp moving to EEEE in cycle 5 of digit 1.
    run_frame(8'hA1, 8'hC6, 8'h83, 8'h88, 40, 14, 16'hEEEE, -100, 0);
    // Frame 4 shows EEEE with en low for 7 cycles inside digit 2's window.
    run_frame(8'h86, 8'h86, 8'h86, 8'h86, 40, 30, 16'h0000, 22, 7);
    bus.dp_mask = 4'b0101;
    // Frame 5: zeros with decimal points on digits 0 and 2; then load 8888.
    run_frame(8'h40, 8'hC0, 8'h40, 8'hC0, 40, 10, 16'h8888, -100, 0);
    // Frame 6: 8888 with dp, interrupted by reset during digit 2.
    run_frame(8'h00, 8'h80, 8'h00, 8'h80, 25, -1, 16'h0, -100, 0);

    #2;
    rst = 1'b1;
    #1;
    chk("async rst dig", {12'h0, bus.dig}, 16'h000F);
    chk("async rst seg", {8'h0, bus.seg}, 16'h00FF);
    chk("async rst frame_done", {15'h0, bus.frame_done}, 16'h0000);
    #2;
    rst = 1'b0;
    // Restart at digit 0 with the shadow cleared even though dsp is 8888.
    run_frame(8'h40, 8'hC0, 8'h40, 8'hC0, 40, -1, 16'h0, -100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
